// File: rtl/gcd_core_hs.sv
// GCD engine by subtractive Euclid, fed and drained over four-phase handshake channels.
// Loops fetch -> compute -> push while activate_0r is held, then acknowledges activate.
module gcd_core_hs #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              initialise_n,
    input  logic              activate_0r,
    output logic              activate_0a,
    output logic              x_0r,
    input  logic              x_0a,
    input  logic [WIDTH-1:0]  x_0d,
    output logic              y_0r,
    input  logic              y_0a,
    input  logic [WIDTH-1:0]  y_0d,
    output logic              z_0r,
    input  logic              z_0a,
    output logic [WIDTH-1:0]  z_0d,
    output logic [ITER_W-1:0] z_iter
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FRTZ  = 3'd2,
        CALC  = 3'd3,
        PUSH  = 3'd4,
        PRTZ  = 3'd5,
        ACK   = 3'd6
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [ITER_W-1:0]  cnt_reg, cnt_next;
    logic [WIDTH-1:0]   z_d_reg, z_d_next;
    logic [ITER_W-1:0]  z_iter_reg, z_iter_next;
    logic               x_r_reg, x_r_next;
    logic               y_r_reg, y_r_next;
    logic               z_r_reg, z_r_next;
    logic               act_a_reg, act_a_next;

    logic               x_done, y_done, found;
    logic [WIDTH-1:0]   result;

    always_ff @(posedge clk) begin
        if (!initialise_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            z_d_reg    <= '0;
            z_iter_reg <= '0;
            x_r_reg    <= 1'b0;
            y_r_reg    <= 1'b0;
            z_r_reg    <= 1'b0;
            act_a_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            z_d_reg    <= z_d_next;
            z_iter_reg <= z_iter_next;
            x_r_reg    <= x_r_next;
            y_r_reg    <= y_r_next;
            z_r_reg    <= z_r_next;
            act_a_reg  <= act_a_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        z_d_next    = z_d_reg;
        z_iter_next = z_iter_reg;
        x_r_next    = x_r_reg;
        y_r_next    = y_r_reg;
        z_r_next    = z_r_reg;
        act_a_next  = act_a_reg;
        x_done      = 1'b0;
        y_done      = 1'b0;
        found       = 1'b0;
        result      = '0;

        case (state_reg)
            IDLE: begin
                if (activate_0r) begin
                    state_next = FETCH;
                    x_r_next   = 1'b1;
                    y_r_next   = 1'b1;
                end
            end
            FETCH: begin
                // A lowered request marks an operand already latched; acks only count while the request is high.
                x_done = !x_r_reg;
                y_done = !y_r_reg;
                if (x_r_reg && x_0a) begin
                    a_next   = x_0d;
                    x_r_next = 1'b0;
                    x_done   = 1'b1;
                end
                if (y_r_reg && y_0a) begin
                    b_next   = y_0d;
                    y_r_next = 1'b0;
                    y_done   = 1'b1;
                end
                if (x_done && y_done)
                    state_next = FRTZ;
            end
            FRTZ: begin
                if (!x_0a && !y_0a) begin
                    state_next = CALC;
                    cnt_next   = '0;
                end
            end
            CALC: begin
                if (a_reg == '0) begin
                    found  = 1'b1;
                    result = b_reg;
                end else if (b_reg == '0 || a_reg == b_reg) begin
                    found  = 1'b1;
                    result = a_reg;
                end else begin
                    if (a_reg > b_reg)
                        a_next = a_reg - b_reg;
                    else
                        b_next = b_reg - a_reg;
                    if (cnt_reg != '1)
                        cnt_next = cnt_reg + 1'b1;
                end
                if (found) begin
                    z_d_next    = result;
                    z_iter_next = cnt_reg;
                    z_r_next    = 1'b1;
                    state_next  = PUSH;
                end
            end
            PUSH: begin
                if (z_r_reg && z_0a) begin
                    z_r_next   = 1'b0;
                    state_next = PRTZ;
                end
            end
            PRTZ: begin
                if (!z_0a) begin
                    if (activate_0r) begin
                        state_next = FETCH;
                        x_r_next   = 1'b1;
                        y_r_next   = 1'b1;
                    end else begin
                        act_a_next = 1'b1;
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                if (!activate_0r) begin
                    act_a_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        activate_0a = act_a_reg;
        x_0r        = x_r_reg;
        y_0r        = y_r_reg;
        z_0r        = z_r_reg;
        z_0d        = z_d_reg;
        z_iter      = z_iter_reg;
    end

endmodule
